inst_fetch: RTL

Instruction-fetch stage between the PC register and the decode stage. Takes the current `pc`/`ce`, runs a request/response handshake with instruction memory, and holds the returned word in a one-entry hold buffer. Raises a stall request while the word for the current `pc` is outstanding, and drives the IF/ID pipeline register. Handles branch flush and pipeline stall.

---
 rtl/inst_fetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch: memory req/resp handshake, one-entry hold buffer, IF/ID register.
// Optional IF_MISALIGN_CHECK_EN: misaligned pc yields a NOP with id_exc instead of a fetch.
module inst_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ce,
  input  logic [4:0]        stall,
  input  logic              br,
  output logic              stall_req,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_valid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic              id_exc
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] req_pc, hold_pc;
  logic [INST_W-1:0] hold_inst;
  logic              kill, hold_vld, hit, misalign;
  logic              unused_stall;

  assign unused_stall = ^{stall[4:2], stall[0]};
  assign hit          = hold_vld && (hold_pc == pc);
  assign stall_req    = !rst && ce && !hit;

`ifdef IF_MISALIGN_CHECK_EN
  logic hold_exc;
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // kill marks an in-flight request whose response must be dropped after a flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      req_pc    <= '0;
      kill      <= 1'b0;
      hold_vld  <= 1'b0;
      hold_pc   <= '0;
      hold_inst <= NOP_INST;
`ifdef IF_MISALIGN_CHECK_EN
      hold_exc  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ce && !hit && !br) begin
            if (misalign) begin
              hold_pc   <= pc;
              hold_inst <= NOP_INST;
              hold_vld  <= 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
              hold_exc  <= 1'b1;
`endif
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= pc;
              req_pc   <= pc;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (br) kill <= 1'b1;
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_valid) begin
            state <= IDLE;
            kill  <= 1'b0;
            if (!kill && !br) begin
              hold_inst <= mem_rdata;
              hold_pc   <= req_pc;
              hold_vld  <= 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
              hold_exc  <= 1'b0;
`endif
            end
          end else if (br) begin
            kill <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      // a flush always invalidates the buffered word, overriding any load above
      if (br) hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc    <= '0;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      id_exc   <= 1'b0;
`endif
    end else if (br) begin
      id_pc    <= '0;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      id_exc   <= 1'b0;
`endif
    end else if (stall[1]) begin
      id_pc    <= id_pc;
    end else if (ce && hit) begin
      id_pc    <= hold_pc;
      id_inst  <= hold_inst;
      id_valid <= 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
      id_exc   <= hold_exc;
`endif
    end else begin
      id_pc    <= '0;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      id_exc   <= 1'b0;
`endif
    end
  end

endmodule
